chip8_fetch: RTL and testbench

Instruction fetch stage that sits directly downstream of the ROM loader. It waits for `rom_ready`, then reads big-endian 16-bit CHIP-8 opcodes from the 4 KiB memory through a byte-wide synchronous read port. It presents each opcode with its address to the decode/execute stage using a valid/ready handshake, and accepts PC redirects from execute for jumps, calls, returns and skips.

---
 rtl/chip8_fetch.sv | 131 +++++++++++++
 tb/tb_chip8_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_fetch.sv
// -----------------------------------------------------------------------------
// chip8_fetch
//
// Instruction fetch stage for the CHIP-8 core. Once the ROM loader reports
// that memory holds a program, this block reads big-endian 16-bit opcodes
// through a byte-wide synchronous read port (1-cycle read latency). It hands
// each opcode and its address to decode/execute over a valid/ready handshake.
// Execute can redirect the PC for jumps, calls, returns and skips.
//
// Ports:
//   clk_in        - clock, all state changes on the rising edge
//   rst_in        - synchronous active-high reset
//   rom_ready     - memory holds a loaded ROM; dropping it restarts fetch
//   mem_rd_en     - byte read request this cycle
//   mem_rd_addr   - byte address of the read request
//   mem_rd_data   - byte for the address requested in the previous cycle
//   instr         - fetched opcode {mem[pc], mem[pc+1]}
//   instr_pc      - address of the high byte of instr
//   instr_valid   - instr / instr_pc hold a valid instruction
//   instr_ready   - consumer takes the instruction this cycle
//   pc_load       - redirect request from execute
//   pc_load_addr  - redirect target
// -----------------------------------------------------------------------------
module chip8_fetch #(
    parameter logic [11:0] RESET_PC = 12'h200
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rom_ready,
    output logic        mem_rd_en,
    output logic [11:0] mem_rd_addr,
    input  logic [7:0]  mem_rd_data,
    output logic [15:0] instr,
    output logic [11:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_load,
    input  logic [11:0] pc_load_addr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        FETCH_LO = 3'd2,
        WAIT_LO  = 3'd3,
        VALID    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] pc;
    logic [11:0] pc_nxt;
    logic        handshake;

    assign handshake = (state == VALID) && instr_ready;

    // Next state and next PC. Losing the ROM outranks a redirect, and a
    // redirect outranks both the sequential advance and the in-flight fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (state == IDLE) begin
            pc_nxt = RESET_PC;
            if (rom_ready) begin
                state_nxt = FETCH_HI;
            end
        end else if (!rom_ready) begin
            state_nxt = IDLE;
            pc_nxt    = RESET_PC;
        end else if (pc_load) begin
            state_nxt = FETCH_HI;
            pc_nxt    = pc_load_addr;
        end else begin
            unique case (state)
                FETCH_HI: state_nxt = FETCH_LO;
                FETCH_LO: state_nxt = WAIT_LO;
                WAIT_LO:  state_nxt = VALID;
                VALID: begin
                    if (handshake) begin
                        state_nxt = FETCH_HI;
                        pc_nxt    = pc + 12'd2;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    pc_nxt    = RESET_PC;
                end
            endcase
        end
    end

    // Outputs are registered from the next state and next PC, so the read
    // port and instr_valid never see a combinational path from the inputs.
    // Opcode bytes are captured only on the uninterrupted path, so an
    // aborted fetch never writes its late read data into instr.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= 12'h000;
            instr       <= 16'h0000;
            instr_pc    <= 12'h000;
            instr_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;

            mem_rd_en   <= (state_nxt == FETCH_HI) || (state_nxt == FETCH_LO);
            instr_valid <= (state_nxt == VALID);

            if (state_nxt == FETCH_HI) begin
                mem_rd_addr <= pc_nxt;
            end else if (state_nxt == FETCH_LO) begin
                mem_rd_addr <= pc_nxt + 12'd1;
            end else begin
                mem_rd_addr <= 12'h000;
            end

            instr_pc <= (state_nxt == VALID) ? pc_nxt : 12'h000;

            if ((state == FETCH_LO) && (state_nxt == WAIT_LO)) begin
                instr[15:8] <= mem_rd_data;
            end
            if ((state == WAIT_LO) && (state_nxt == VALID)) begin
                instr[7:0] <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_chip8_fetch.sv
// -----------------------------------------------------------------------------
// tb_chip8_fetch
//
// Bench for chip8_fetch. A 4 KiB byte memory with a 1-cycle read port feeds
// the fetch stage. A transaction-level model tracks the PC and how many
// cycles into the current 4-cycle fetch window the stage is, and derives the
// expected read port and instruction straight from the memory array. A
// compare process checks the DUT against it on every falling edge; directed
// checks with literal values pin the model to the expected behaviour.
// -----------------------------------------------------------------------------
module tb_chip8_fetch;

    localparam logic [11:0] RESET_PC = 12'h200;

    logic        clk_in;
    logic        rst_in;
    logic        rom_ready;
    logic        mem_rd_en;
    logic [11:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_load;
    logic [11:0] pc_load_addr;

    int checks;
    int failures;

    logic [7:0]  mem [4096];
    logic [11:0] rd_log [$];
    logic        compare_on;

    chip8_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rom_ready    (rom_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Synchronous byte memory: data for a request appears the next cycle
    always @(posedge clk_in) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
        end
    end

    // Record every issued read address so ordering can be checked
    always @(negedge clk_in) begin
        if (mem_rd_en) begin
            rd_log.push_back(mem_rd_addr);
        end
    end

    // Transaction model: m_active says a fetch window is running, m_k counts
    // cycles into it (0: read pc, 1: read pc+1, 2: waiting, 3: offering).
    logic        m_active;
    int          m_k;
    logic [11:0] m_pc;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_pc     <= RESET_PC;
        end else if (!m_active) begin
            m_pc <= RESET_PC;
            if (rom_ready) begin
                m_active <= 1'b1;
                m_k      <= 0;
            end
        end else if (!rom_ready) begin
            m_active <= 1'b0;
            m_pc     <= RESET_PC;
        end else if (pc_load) begin
            m_pc <= pc_load_addr;
            m_k  <= 0;
        end else if (m_k == 3) begin
            if (instr_ready) begin
                m_pc <= m_pc + 12'd2;
                m_k  <= 0;
            end
        end else begin
            m_k <= m_k + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Compare DUT against the model every cycle once out of initial reset
    always @(negedge clk_in) begin
        if (compare_on) begin
            logic        e_en;
            logic        e_valid;
            logic [11:0] e_addr;
            logic [11:0] pc_next;
            e_en    = m_active && (m_k < 2);
            e_valid = m_active && (m_k == 3);
            pc_next = m_pc + 12'd1;
            e_addr  = (m_k == 0) ? m_pc : pc_next;
            checkOutput("model_rd_en", {15'd0, mem_rd_en}, {15'd0, e_en});
            checkOutput("model_valid", {15'd0, instr_valid}, {15'd0, e_valid});
            if (e_en) begin
                checkOutput("model_rd_addr", {4'd0, mem_rd_addr}, {4'd0, e_addr});
            end
            if (e_valid) begin
                checkOutput("model_instr", instr, {mem[m_pc], mem[pc_next]});
                checkOutput("model_instr_pc", {4'd0, instr_pc}, {4'd0, m_pc});
            end
        end
    end

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic rr, input logic ir, input logic pl,
                                 input logic [11:0] pla);
        rom_ready    = rr;
        instr_ready  = ir;
        pc_load      = pl;
        pc_load_addr = pla;
    endtask

    task automatic checkLog(input string name, input int idx, input logic [11:0] exp_addr);
        logic [15:0] got;
        got = (rd_log.size() > idx) ? {4'd0, rd_log[idx]} : 16'hFFFF;
        checkOutput(name, got, {4'd0, exp_addr});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_en"}, {15'd0, mem_rd_en}, 16'd0);
        checkOutput({tag, "_rd_addr"}, {4'd0, mem_rd_addr}, 16'd0);
        checkOutput({tag, "_instr"}, instr, 16'h0000);
        checkOutput({tag, "_instr_pc"}, {4'd0, instr_pc}, 16'd0);
        checkOutput({tag, "_valid"}, {15'd0, instr_valid}, 16'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        compare_on  = 1'b0;
        mem_rd_data = 8'h00;
        rst_in      = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);

        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'((i * 7) + 3);
        end
        mem[12'h200] = 8'h00;
        mem[12'h201] = 8'hE0;
        mem[12'h202] = 8'h12;
        mem[12'h203] = 8'h34;
        mem[12'h3A5] = 8'h6A;
        mem[12'h3A6] = 8'h42;
        mem[12'hFFF] = 8'hAB;
        mem[12'h000] = 8'hCD;

        tick(2);
        rst_in     = 1'b0;
        compare_on = 1'b1;
        tick(1);
        checkResetValues("reset");

        // Basic fetch: two sequential opcodes, 4 cycles each
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        rd_log.delete();
        tick(4);
        checkOutput("basic_valid0", {15'd0, instr_valid}, 16'd1);
        checkOutput("basic_instr0", instr, 16'h00E0);
        checkOutput("basic_pc0", {4'd0, instr_pc}, 16'h0200);
        tick(4);
        instr_ready = 1'b0;
        checkOutput("basic_instr1", instr, 16'h1234);
        checkOutput("basic_pc1", {4'd0, instr_pc}, 16'h0202);
        checkLog("basic_rd0", 0, 12'h200);
        checkLog("basic_rd1", 1, 12'h201);
        checkLog("basic_rd2", 2, 12'h202);
        checkLog("basic_rd3", 3, 12'h203);

        // Back-pressure: hold for 10 cycles, nothing moves, no reads
        rd_log.delete();
        tick(10);
        checkOutput("bp_valid", {15'd0, instr_valid}, 16'd1);
        checkOutput("bp_instr", instr, 16'h1234);
        checkOutput("bp_pc", {4'd0, instr_pc}, 16'h0202);
        checkOutput("bp_no_reads", 16'(rd_log.size()), 16'd0);
        instr_ready = 1'b1;
        tick(1);
        checkOutput("bp_valid_drop", {15'd0, instr_valid}, 16'd0);
        tick(3);
        instr_ready = 1'b0;
        checkOutput("bp_next_pc", {4'd0, instr_pc}, 16'h0204);
        checkLog("bp_next_rd", 0, 12'h204);

        // Redirect while in FETCH_LO
        instr_ready = 1'b1;
        tick(2);
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h3A5);
        tick(1);
        pc_load = 1'b0;
        rd_log.delete();
        checkOutput("rd_lo_valid", {15'd0, instr_valid}, 16'd0);
        tick(3);
        checkOutput("rd_lo_pc", {4'd0, instr_pc}, 16'h03A5);
        checkOutput("rd_lo_instr", instr, 16'h6A42);
        checkLog("rd_lo_first", 0, 12'h3A5);

        // Redirect coinciding with a handshake: target beats pc+2
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h3A5);
        rd_log.delete();
        tick(1);
        pc_load = 1'b0;
        tick(3);
        checkOutput("rd_hs_pc", {4'd0, instr_pc}, 16'h03A5);
        checkLog("rd_hs_first", 0, 12'h3A5);

        // Wrap-around at the top of memory
        applyStimulus(1'b1, 1'b1, 1'b1, 12'hFFF);
        tick(1);
        pc_load = 1'b0;
        rd_log.delete();
        tick(3);
        checkOutput("wrap_instr", instr, 16'hABCD);
        checkOutput("wrap_pc", {4'd0, instr_pc}, 16'h0FFF);
        checkLog("wrap_rd0", 0, 12'hFFF);
        checkLog("wrap_rd1", 1, 12'h000);
        tick(1);
        checkOutput("wrap_next_en", {15'd0, mem_rd_en}, 16'd1);
        checkOutput("wrap_next_addr", {4'd0, mem_rd_addr}, 16'h0001);

        // ROM reload while offering the instruction at 0x240
        applyStimulus(1'b1, 1'b1, 1'b1, 12'h240);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
        tick(3);
        checkOutput("reload_pc", {4'd0, instr_pc}, 16'h0240);
        rom_ready = 1'b0;
        tick(1);
        checkOutput("reload_valid", {15'd0, instr_valid}, 16'd0);
        rd_log.delete();
        tick(2);
        checkOutput("reload_idle", 16'(rd_log.size()), 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        tick(1);
        checkOutput("reload_addr", {4'd0, mem_rd_addr}, 16'h0200);

        // Reset asserted in WAIT_LO
        tick(2);
        rst_in = 1'b1;
        tick(1);
        checkResetValues("midrst");
        rst_in = 1'b0;
        tick(1);
        checkOutput("midrst_en", {15'd0, mem_rd_en}, 16'd1);
        checkOutput("midrst_addr", {4'd0, mem_rd_addr}, 16'h0200);
        tick(3);
        checkOutput("midrst_instr", instr, 16'h00E0);

        tick(2);
        compare_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
